hex_arbiter: RTL and testbench

HEX_ARBITER -- requirements
Module: hex_arbiter

---
 rtl/hex_arbiter.sv | 133 +++++++++++++
 tb/tb_hex_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_arbiter.sv
// Two-requester round-robin arbiter that owns a 4-digit seven-segment display.
// Ports: clk, rst (async high), req[1:0], data0/data1 -> grant, done, busy, HEX0..HEX3.
module hex_arbiter #(
  parameter int unsigned TICK_DIV   = 50000000,
  parameter int unsigned HOLD_TICKS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  output logic [1:0]  grant,
  output logic        done,
  output logic        busy,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3
);

  localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);
  localparam logic [7:0]  HOLD_LAST = 8'(HOLD_TICKS - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             done_q, done_d;
  logic [31:0]      presc_q, presc_d;
  logic [7:0]       hold_q, hold_d;
  logic [15:0]      data_q, data_d;
  logic             last_q, last_d;
  logic [3:0][6:0]  hex_q, hex_d;
  logic             win;
  logic             tick_end;

  function automatic logic [6:0] seg(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      done_q  <= 1'b0;
      presc_q <= '0;
      hold_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b1;
      hex_q   <= {4{7'h7F}};
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      presc_q <= presc_d;
      hold_q  <= hold_d;
      data_q  <= data_d;
      last_q  <= last_d;
      hex_q   <= hex_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    done_d   = 1'b0;
    presc_d  = presc_q;
    hold_d   = hold_q;
    data_d   = data_q;
    last_d   = last_q;
    hex_d    = hex_q;
    win      = 1'b0;
    tick_end = (presc_q == TICK_LAST);
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          // On a tie the requester that did not win last time goes first.
          win     = (req == 2'b11) ? ~last_q : req[1];
          data_d  = win ? data1 : data0;
          for (int k = 0; k < 4; k++)
            hex_d[k] = seg(data_d[4*k +: 4]);
          grant_d = win ? 2'b10 : 2'b01;
          last_d  = win;
          presc_d = '0;
          hold_d  = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // Release when the hold time is spent or the owner lets go.
        if ((tick_end && hold_q == HOLD_LAST) || ~|(req & grant_q)) begin
          grant_d = 2'b00;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (tick_end) begin
          presc_d = '0;
          hold_d  = hold_q + 8'd1;
        end else begin
          presc_d = presc_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = (state_q == HOLD);
  assign HEX0  = hex_q[0];
  assign HEX1  = hex_q[1];
  assign HEX2  = hex_q[2];
  assign HEX3  = hex_q[3];

endmodule

// File: tb/tb_hex_arbiter.sv
// Scoreboard bench for hex_arbiter with TICK_DIV=4, HOLD_TICKS=2.
// Stimulus pushes expected grant/done events; a negedge monitor pops and compares.
module tb_hex_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [15:0] data0;
  logic [15:0] data1;
  logic [1:0]  grant;
  logic        done;
  logic        busy;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3;

  hex_arbiter #(.TICK_DIV(4), .HOLD_TICKS(2)) dut (
    .clk(clk), .rst(rst), .req(req),
    .data0(data0), .data1(data1),
    .grant(grant), .done(done), .busy(busy),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3)
  );

  localparam logic [27:0] H3210 = {7'h30, 7'h24, 7'h79, 7'h40};
  localparam logic [27:0] HFEDC = {7'h0E, 7'h06, 7'h21, 7'h46};
  localparam logic [27:0] H0000 = {4{7'h40}};
  localparam logic [27:0] HFFFF = {4{7'h0E}};
  localparam logic [27:0] BLANK = {4{7'h7F}};

  typedef struct {
    logic [1:0]  g;
    logic [27:0] hex;
    int          gap;
  } gexp_t;

  typedef struct {
    int          len;
    logic [27:0] hex;
  } dexp_t;

  gexp_t gq[$];
  dexp_t dq[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int len = 0;
  int last_done = 0;
  int n_grant = 0;
  int n_done = 0;
  logic [1:0] prev_g = 2'b00;
  logic [27:0] obs_hex;

  assign obs_hex = {HEX3, HEX2, HEX1, HEX0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic push_g(input logic [1:0] g, input logic [27:0] h,
                        input int gap);
    gexp_t e;
    e.g = g;
    e.hex = h;
    e.gap = gap;
    gq.push_back(e);
  endtask

  task automatic push_d(input int l, input logic [27:0] h);
    dexp_t e;
    e.len = l;
    e.hex = h;
    dq.push_back(e);
  endtask

  always @(negedge clk) begin
    gexp_t ge;
    dexp_t de;
    cyc++;
    if (!rst) begin
      check("busy_iff_grant", 32'(busy), 32'(grant != 2'b00));
      check("done_excl_grant", 32'(done && grant != 2'b00), 32'd0);
      check("grant_onehot", 32'(grant == 2'b11), 32'd0);
      if (grant != 2'b00 && prev_g == 2'b00) begin
        if (gq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_grant: got %b want none", grant);
        end else begin
          ge = gq.pop_front();
          check("grant", 32'(grant), 32'(ge.g));
          check("grant_hex", 32'(obs_hex), 32'(ge.hex));
          if (ge.gap >= 0)
            check("grant_gap", 32'(cyc - last_done), 32'(ge.gap));
        end
        len = 0;
        n_grant++;
      end
      if (grant != 2'b00)
        len++;
      if (done) begin
        if (dq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got 1 want 0");
        end else begin
          de = dq.pop_front();
          check("hold_len", 32'(len), 32'(de.len));
          check("done_hex", 32'(obs_hex), 32'(de.hex));
        end
        last_done = cyc;
        n_done++;
      end
    end
    prev_g = grant;
  end

  task automatic wait_done(input int k);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #1;
      if (n_done >= k) return;
    end
    total++;
    bad++;
    $display("FAIL timeout_done: got %0d want %0d", n_done, k);
  endtask

  task automatic wait_grant(input int k);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #1;
      if (n_grant >= k) return;
    end
    total++;
    bad++;
    $display("FAIL timeout_grant: got %0d want %0d", n_grant, k);
  endtask

  initial begin
    int nd;
    int ng;
    rst = 1'b1;
    req = 2'b00;
    data0 = 16'h0000;
    data1 = 16'h0000;
    repeat (3) @(negedge clk);
    #1;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hex", 32'(obs_hex), 32'(BLANK));

    // single requester, full hold, back-to-back regrant
    push_g(2'b01, H3210, -1);
    push_d(8, H3210);
    push_g(2'b01, H3210, 1);
    push_d(8, H3210);
    nd = n_done;
    rst = 1'b0;
    data0 = 16'h3210;
    req = 2'b01;
    wait_done(nd + 2);
    req = 2'b00;

    // data changes mid-hold are ignored
    repeat (2) @(negedge clk);
    #1;
    push_g(2'b01, H0000, -1);
    push_d(8, H0000);
    push_g(2'b01, HFFFF, 1);
    push_d(8, HFFFF);
    nd = n_done;
    ng = n_grant;
    data0 = 16'h0000;
    req = 2'b01;
    wait_grant(ng + 1);
    repeat (2) @(negedge clk);
    #1;
    data0 = 16'hFFFF;
    wait_done(nd + 2);
    req = 2'b00;

    // early release by requester 1 on hold cycle 3
    repeat (2) @(negedge clk);
    #1;
    push_g(2'b10, HFEDC, -1);
    push_d(3, HFEDC);
    nd = n_done;
    ng = n_grant;
    data1 = 16'hFEDC;
    req = 2'b10;
    wait_grant(ng + 1);
    repeat (2) @(negedge clk);
    #1;
    req = 2'b00;
    wait_done(nd + 1);
    repeat (3) @(negedge clk);
    #1;
    check("hex_retained", 32'(obs_hex), 32'(HFEDC));
    check("idle_grant", 32'(grant), 32'd0);

    // reset mid-hold aborts without done
    push_g(2'b01, H3210, -1);
    ng = n_grant;
    nd = n_done;
    data0 = 16'h3210;
    req = 2'b01;
    wait_grant(ng + 1);
    repeat (4) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_grant", 32'(grant), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hex", 32'(obs_hex), 32'(BLANK));
    req = 2'b11;
    repeat (2) @(negedge clk);
    #1;

    // both requesting: round robin from requester 0
    push_g(2'b01, H3210, -1);
    push_d(8, H3210);
    push_g(2'b10, HFEDC, 1);
    push_d(8, HFEDC);
    push_g(2'b01, H3210, 1);
    push_d(8, H3210);
    rst = 1'b0;
    wait_done(nd + 3);
    req = 2'b00;
    repeat (5) @(negedge clk);
    #1;
    check("no_extra_done", 32'(n_done), 32'(nd + 3));
    check("grant_q_empty", 32'(gq.size()), 32'd0);
    check("done_q_empty", 32'(dq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
